// File: rtl/data_mem_arbiter.sv
// Two-port (scalar/vector) arbiter in front of a single-port synchronous word RAM.
// Registered outputs follow the current state; read data appears the cycle after the ready pulse.
module data_mem_arbiter #(
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_req,
    input  logic        scl_we,
    input  logic [31:0] scl_addr,
    input  logic [31:0] scl_wdata,
    output logic [31:0] scl_rdata,
    output logic        scl_ready,
    input  logic        vec_req,
    input  logic        vec_we,
    input  logic [31:0] vec_addr,
    input  logic [63:0] vec_wdata,
    output logic [63:0] vec_rdata,
    output logic        vec_ready,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, S_ACC, S_RSP, V_LO, V_HI, V_RSP} state_t;

    state_t      state_q, state_d;
    logic        last_vec_q, last_vec_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        ram_we_q, ram_we_d;
    logic        scl_ready_q, scl_ready_d;
    logic        vec_ready_q, vec_ready_d;
    logic [31:0] scl_rdata_q, scl_rdata_d;
    logic [63:0] vec_rdata_q, vec_rdata_d;
    logic        busy_q, busy_d;
    logic        grant_s, grant_v;

    // Scalar wins a tie only when the vector port was granted last.
    assign grant_s = scl_req && (!vec_req || last_vec_q);
    assign grant_v = vec_req && !grant_s;

    always_comb begin
        state_d     = state_q;
        last_vec_d  = last_vec_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        scl_ready_d = 1'b0;
        vec_ready_d = 1'b0;
        scl_rdata_d = scl_rdata_q;
        vec_rdata_d = vec_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d     = S_ACC;
                    last_vec_d  = 1'b0;
                    we_d        = scl_we;
                    addr_d      = scl_addr;
                    wdata_d     = {32'h0, scl_wdata};
                    ram_addr_d  = scl_addr;
                    ram_wdata_d = scl_wdata;
                    ram_we_d    = scl_we;
                end else if (grant_v) begin
                    state_d     = V_LO;
                    last_vec_d  = 1'b1;
                    we_d        = vec_we;
                    addr_d      = vec_addr;
                    wdata_d     = vec_wdata;
                    ram_addr_d  = vec_addr;
                    ram_wdata_d = vec_wdata[31:0];
                    ram_we_d    = vec_we;
                end
            end
            S_ACC: begin
                state_d     = S_RSP;
                scl_ready_d = 1'b1;
            end
            S_RSP: begin
                state_d = IDLE;
                if (!we_q) scl_rdata_d = ram_rdata;
            end
            V_LO: begin
                state_d     = V_HI;
                ram_addr_d  = addr_q + 32'(ADDR_STEP);
                ram_wdata_d = wdata_q[63:32];
                ram_we_d    = we_q;
            end
            V_HI: begin
                state_d     = V_RSP;
                vec_ready_d = 1'b1;
                if (!we_q) vec_rdata_d[31:0] = ram_rdata;
            end
            V_RSP: begin
                state_d = IDLE;
                if (!we_q) vec_rdata_d[63:32] = ram_rdata;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_vec_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            scl_ready_q <= 1'b0;
            vec_ready_q <= 1'b0;
            scl_rdata_q <= '0;
            vec_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_vec_q  <= last_vec_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            scl_ready_q <= scl_ready_d;
            vec_ready_q <= vec_ready_d;
            scl_rdata_q <= scl_rdata_d;
            vec_rdata_q <= vec_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign scl_rdata = scl_rdata_q;
    assign scl_ready = scl_ready_q;
    assign vec_rdata = vec_rdata_q;
    assign vec_ready = vec_ready_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256-word synchronous RAM model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_req, scl_we;
    logic [31:0] scl_addr, scl_wdata, scl_rdata;
    logic        scl_ready;
    logic        vec_req, vec_we;
    logic [31:0] vec_addr;
    logic [63:0] vec_wdata, vec_rdata;
    logic        vec_ready;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, busy;

    logic [31:0] mem [0:255];
    int checks = 0;
    int failures = 0;
    int wcount = 0;
    int both_ready = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_STEP(1)) dut (
        .clk(clk), .rst(rst),
        .scl_req(scl_req), .scl_we(scl_we), .scl_addr(scl_addr), .scl_wdata(scl_wdata),
        .scl_rdata(scl_rdata), .scl_ready(scl_ready),
        .vec_req(vec_req), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .vec_rdata(vec_rdata), .vec_ready(vec_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
            wcount <= wcount + 1;
        end
        ram_rdata <= mem[ram_addr[7:0]];
    end

    always @(negedge clk) if (scl_ready && vec_ready) both_ready <= both_ready + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int got;
        int wsnap;
        logic [3:0] ord;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        ram_rdata = '0;
        rst = 1'b1;
        scl_req = 0; scl_we = 0; scl_addr = '0; scl_wdata = '0;
        vec_req = 0; vec_we = 0; vec_addr = '0; vec_wdata = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", {scl_ready, vec_ready, ram_we}, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rdata", {scl_rdata, vec_rdata}, 0);
        rst = 1'b0;

        // scalar write 0xDEADBEEF to 0x10; inputs scrambled once granted
        scl_req = 1; scl_we = 1; scl_addr = 32'h10; scl_wdata = 32'hDEADBEEF;
        tick();
        chk("sw_acc_we", ram_we, 1);
        chk("sw_acc_addr", ram_addr, 32'h10);
        chk("sw_acc_wdata", ram_wdata, 32'hDEADBEEF);
        chk("sw_acc_busy", {busy, scl_ready}, 2'b10);
        scl_addr = 32'h55; scl_wdata = 32'h0;
        tick();
        chk("sw_rsp_ready", {scl_ready, ram_we}, 2'b10);
        scl_req = 0;
        tick();
        chk("sw_idle", {busy, scl_ready, ram_we}, 0);
        chk("sw_mem", mem[8'h10], 32'hDEADBEEF);
        chk("sw_idle_addr_hold", ram_addr, 32'h10);

        // scalar read back
        scl_req = 1; scl_we = 0; scl_addr = 32'h10;
        tick();
        chk("sr_acc_we", ram_we, 0);
        tick();
        chk("sr_rsp_ready", scl_ready, 1);
        scl_req = 0;
        tick();
        chk("sr_rdata", scl_rdata, 32'hDEADBEEF);

        // vector write then read at 0x20
        vec_req = 1; vec_we = 1; vec_addr = 32'h20; vec_wdata = 64'h11112222_33334444;
        tick();
        chk("vw_lo", {ram_we, ram_addr, ram_wdata}, {1'b1, 32'h20, 32'h33334444});
        tick();
        chk("vw_hi", {ram_we, ram_addr, ram_wdata}, {1'b1, 32'h21, 32'h11112222});
        chk("vw_hi_noready", vec_ready, 0);
        tick();
        chk("vw_rsp", {vec_ready, ram_we}, 2'b10);
        vec_req = 0;
        tick();
        chk("vw_mem_lo", mem[8'h20], 32'h33334444);
        chk("vw_mem_hi", mem[8'h21], 32'h11112222);
        vec_req = 1; vec_we = 0;
        tick(); tick();
        chk("vr_hi_noready", vec_ready, 0);
        tick();
        chk("vr_rsp_ready", vec_ready, 1);
        vec_req = 0;
        tick();
        chk("vr_rdata", vec_rdata, 64'h11112222_33334444);
        chk("scl_rdata_held", scl_rdata, 32'hDEADBEEF);

        // round-robin from reset with both requests held
        rst = 1; tick(); rst = 0;
        scl_req = 1; scl_we = 0; scl_addr = 32'h10;
        vec_req = 1; vec_we = 0; vec_addr = 32'h20;
        got = 0; ord = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            tick();
            if (scl_ready) begin ord[got] = 1'b0; got++; end
            else if (vec_ready) begin ord[got] = 1'b1; got++; end
        end
        scl_req = 0; vec_req = 0;
        chk("rr_count", got, 4);
        chk("rr_order", ord, 4'b1010);
        tick();

        // vector read wrapping at 0xFFFFFFFF
        vec_req = 1; vec_we = 0; vec_addr = 32'hFFFF_FFFF;
        tick();
        chk("wrap_lo_addr", ram_addr, 32'hFFFF_FFFF);
        tick();
        chk("wrap_hi_addr", ram_addr, 32'h0);
        tick();
        vec_req = 0;
        tick();
        chk("wrap_rdata", vec_rdata, 64'hA0000000_A00000FF);

        // reset during V_HI of a vector write
        vec_req = 1; vec_we = 1; vec_addr = 32'h40; vec_wdata = 64'hCAFE0002_CAFE0001;
        tick(); tick();
        chk("abort_in_vhi", {ram_we, ram_addr}, {1'b1, 32'h41});
        rst = 1; vec_req = 0;
        tick();
        rst = 0;
        chk("abort_idle", {busy, ram_we, vec_ready}, 0);
        wsnap = wcount;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (vec_ready || ram_we) got++;
        end
        chk("abort_no_activity", got, 0);
        chk("abort_no_write", wcount, wsnap);

        // scalar request arriving during V_LO waits, then uses inputs seen in IDLE
        vec_req = 1; vec_we = 0; vec_addr = 32'h20;
        tick();
        scl_req = 1; scl_we = 0; scl_addr = 32'h21;
        tick();
        chk("wait_vhi", {busy, scl_ready, ram_addr}, {1'b1, 1'b0, 32'h21});
        scl_addr = 32'h10;
        tick();
        chk("wait_vready", {vec_ready, scl_ready}, 2'b10);
        vec_req = 0;
        tick();
        chk("wait_idle", busy, 0);
        tick();
        chk("wait_sacc_addr", ram_addr, 32'h10);
        tick();
        chk("wait_sready", scl_ready, 1);
        scl_req = 0;
        tick();
        chk("wait_srdata", scl_rdata, 32'hDEADBEEF);
        chk("wait_vrdata", vec_rdata, 64'h11112222_33334444);
        chk("never_both_ready", both_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
